// File: rtl/rv32i_types.sv
// Shared core types: register-index widths, the ROB entry layout and the
// wrap-aware ROB pointer increment.
package rv32i_types;

    localparam int ARCH_WIDTH = 5;
    localparam int PRF_WIDTH  = 7;
    localparam int ROB_DEPTH  = 32;

    typedef struct packed {
        logic                  valid;
        logic                  ready;
        logic [ARCH_WIDTH-1:0] arch;
        logic [PRF_WIDTH-1:0]  phys;
        logic                  br_pred_valid;
        logic                  br_pred_taken;
    } rob_entry_t;

    // Increment an (idx_w+1)-bit pointer; the top bit acts as the wrap flag.
    function automatic logic [31:0] rob_ptr_inc(input logic [31:0] ptr, input int unsigned idx_w);
        return (ptr + 32'd1) & ((32'd1 << (idx_w + 1)) - 32'd1);
    endfunction

endpackage

// File: rtl/reorder_buffer.sv
// In-order retirement queue: dispatch allocates at tail, the CDB marks entries
// ready, and the head retires to the RRAT/free list once ready.
module reorder_buffer
    import rv32i_types::rob_entry_t;
    import rv32i_types::rob_ptr_inc;
#(
    parameter int ROB_DEPTH  = rv32i_types::ROB_DEPTH,
    parameter int ARCH_WIDTH = rv32i_types::ARCH_WIDTH,
    parameter int PRF_WIDTH  = rv32i_types::PRF_WIDTH
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        flush,
    input  logic                        dispatch_valid,
    input  logic [ARCH_WIDTH-1:0]       dispatch_rd_s,
    input  logic [PRF_WIDTH-1:0]        dispatch_pd_s,
    output logic                        dispatch_ready,
    output logic [$clog2(ROB_DEPTH)-1:0] dispatch_rob_idx,
    input  logic                        cdb_valid,
    input  logic [$clog2(ROB_DEPTH)-1:0] cdb_rob_idx,
    output logic                        commit_valid,
    output logic [ARCH_WIDTH-1:0]       commit_rd_s,
    output logic [PRF_WIDTH-1:0]        commit_pd_s,
    output logic [$clog2(ROB_DEPTH)-1:0] commit_rob_idx,
    input  logic                        commit_ready,
    output logic                        rob_empty,
    output logic [$clog2(ROB_DEPTH):0]  rob_count
);

    localparam int IDX_W = $clog2(ROB_DEPTH);
    localparam int PTR_W = IDX_W + 1;

    rob_entry_t         entries [ROB_DEPTH];
    logic [PTR_W-1:0]   head;
    logic [PTR_W-1:0]   tail;
    logic [IDX_W-1:0]   head_idx;
    logic [IDX_W-1:0]   tail_idx;
    logic               full;
    logic               enq;
    logic               deq;

    assign head_idx = head[IDX_W-1:0];
    assign tail_idx = tail[IDX_W-1:0];

    // Same slot index with opposite wrap bits means the tail has lapped the head.
    assign full      = (head_idx == tail_idx) && (head[IDX_W] != tail[IDX_W]);
    assign rob_empty = (head == tail);
    assign rob_count = tail - head;

    assign dispatch_ready   = !full;
    assign dispatch_rob_idx = tail_idx;

    assign commit_valid   = entries[head_idx].valid && entries[head_idx].ready;
    assign commit_rd_s    = entries[head_idx].arch;
    assign commit_pd_s    = entries[head_idx].phys;
    assign commit_rob_idx = head_idx;

    assign enq = dispatch_valid && !full;
    assign deq = commit_valid && commit_ready;

    // NOTE: only the valid/ready flags are cleared on reset/flush; the payload
    // fields are never observed while valid=0, so they need no reset.
    always_ff @(posedge clk) begin
        if (!rst || flush) begin
            head <= '0;
            tail <= '0;
            for (int i = 0; i < ROB_DEPTH; i++) begin
                entries[i].valid <= 1'b0;
                entries[i].ready <= 1'b0;
            end
        end else begin
            // Later assignments win: an enqueue over a CDB hit leaves ready=0,
            // and a retirement clears valid regardless of a same-cycle CDB.
            if (cdb_valid && entries[cdb_rob_idx].valid) begin
                entries[cdb_rob_idx].ready <= 1'b1;
            end
            if (enq) begin
                entries[tail_idx] <= '{valid: 1'b1, ready: 1'b0,
                                       arch: dispatch_rd_s, phys: dispatch_pd_s,
                                       br_pred_valid: 1'b0, br_pred_taken: 1'b0};
                tail <= PTR_W'(rob_ptr_inc(32'(tail), IDX_W));
            end
            if (deq) begin
                entries[head_idx].valid <= 1'b0;
                head <= PTR_W'(rob_ptr_inc(32'(head), IDX_W));
            end
        end
    end

endmodule
